// File: rtl/ifs_bank_ctrl_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// ifs_ctrl_pkg : shared types and helpers for the input-register bank sequencer
// Rev 1.0
// ------------------------------------------------------------------
package ifs_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PRESET = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RUN    = 2'd3
    } ifs_state_e;

    // Widest bank the majority helper handles; callers zero-extend and truncate.
    localparam int IFS_MAX_W = 64;

    function automatic logic [IFS_MAX_W-1:0] maj3(
        input logic [IFS_MAX_W-1:0] a,
        input logic [IFS_MAX_W-1:0] b,
        input logic [IFS_MAX_W-1:0] c
    );
        return (a & b) | (a & c) | (b & c);
    endfunction

    // The phase counter loads at most max(a,b)-1, so clog2(max) bits suffice.
    function automatic int ctr_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ifs_bank_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// ifs_bank_if : control, bank-sample and filtered-word handshake bundle
// Rev 1.0
// ------------------------------------------------------------------
interface ifs_bank_if
    import ifs_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) ();

    logic             en;
    logic [DIV_W-1:0] div;
    logic [WIDTH-1:0] q;
    logic             ready;
    logic             clr_ovf;

    logic             pd;
    logic             sample;
    logic [WIDTH-1:0] dout;
    logic             valid;
    logic             ovf;
    logic             busy;
    ifs_state_e       state;

    modport master (
        output en, div, q, ready, clr_ovf,
        input  pd, sample, dout, valid, ovf, busy, state
    );

    modport slave (
        input  en, div, q, ready, clr_ovf,
        output pd, sample, dout, valid, ovf, busy, state
    );

endinterface

`default_nettype wire

// File: rtl/ifs_bank_ctrl_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// ifs_sample_timer : reloadable down-counter producing the registered SAMPLE strobe
// Rev 1.0
// ------------------------------------------------------------------
module ifs_sample_timer #(
    parameter int DIV_W = 8
) (
    input  wire logic             sclk_i,
    input  wire logic             rstn_i,
    input  wire logic             clr_i,
    input  wire logic             load_i,
    input  wire logic [DIV_W-1:0] div_i,
    output logic                  sample_o
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] rld_q, rld_d;
    logic             act_q, act_d;
    logic             sample_d;

    always_comb begin
        cnt_d = cnt_q;
        rld_d = rld_q;
        act_d = act_q;
        if (clr_i) begin
            cnt_d = '0;
            act_d = 1'b0;
        end else if (load_i) begin
            cnt_d = div_i;
            rld_d = div_i;
            act_d = 1'b1;
        end else if (act_q) begin
            if (cnt_q == '0) begin
                cnt_d = rld_q;
            end else begin
                cnt_d = cnt_q - DIV_W'(1);
            end
        end
        // Strobe is registered from the next count so it lines up with cnt_q==0.
        sample_d = act_d && (cnt_d == '0);
    end

    always_ff @(posedge sclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q    <= '0;
            rld_q    <= '0;
            act_q    <= 1'b0;
            sample_o <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            rld_q    <= rld_d;
            act_q    <= act_d;
            sample_o <= sample_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ifs_bank_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// ifs_bank_ctrl : preset/settle/sample sequencer with 3-sample majority filter
// Rev 1.0
// ------------------------------------------------------------------
module ifs_bank_ctrl
    import ifs_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DIV_W     = 8,
    parameter int PD_CYCLES = 2,
    parameter int SETTLE    = 4
) (
    input  wire logic sclk_i,
    input  wire logic rstn_i,
    ifs_bank_if.slave bus
);

    localparam int               CNT_W     = ctr_width(PD_CYCLES, SETTLE);
    localparam logic [CNT_W-1:0] C_PD_LOAD = CNT_W'(PD_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_ST_LOAD = CNT_W'((SETTLE > 0) ? SETTLE - 1 : 0);

    ifs_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pd_q, pd_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] h0_q, h0_d;
    logic [WIDTH-1:0] h1_q, h1_d;
    logic [1:0]       scnt_q, scnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;

    logic             tmr_sample;
    logic             tmr_clr;
    logic             tmr_load;
    logic             produce;
    logic             ovf_set;
    logic [WIDTH-1:0] word;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!bus.en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_PRESET;
                    cnt_d   = C_PD_LOAD;
                end
                ST_PRESET: begin
                    if (cnt_q == '0) begin
                        if (SETTLE > 0) begin
                            state_d = ST_SETTLE;
                            cnt_d   = C_ST_LOAD;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (cnt_q == '0) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        // PD/BUSY follow the next state so they are registered yet aligned with it.
        pd_d   = (state_d == ST_PRESET);
        busy_d = (state_d == ST_PRESET) || (state_d == ST_SETTLE);
    end

    assign tmr_clr  = (state_d != ST_RUN);
    assign tmr_load = (state_d == ST_RUN) && (state_q != ST_RUN);

    ifs_sample_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .sclk_i   (sclk_i),
        .rstn_i   (rstn_i),
        .clr_i    (tmr_clr),
        .load_i   (tmr_load),
        .div_i    (bus.div),
        .sample_o (tmr_sample)
    );

    always_comb begin
        word    = WIDTH'(maj3(IFS_MAX_W'(bus.q), IFS_MAX_W'(h0_q), IFS_MAX_W'(h1_q)));
        produce = tmr_sample && (scnt_q >= 2'd2);
        h0_d    = h0_q;
        h1_d    = h1_q;
        scnt_d  = scnt_q;
        dout_d  = dout_q;
        valid_d = valid_q;
        ovf_set = 1'b0;
        if (!bus.en) begin
            h0_d    = '0;
            h1_d    = '0;
            scnt_d  = '0;
            valid_d = 1'b0;
        end else begin
            if (tmr_sample) begin
                h1_d = h0_q;
                h0_d = bus.q;
                if (scnt_q != 2'd3) begin
                    scnt_d = scnt_q + 2'd1;
                end
            end
            if (produce) begin
                if (!valid_q || bus.ready) begin
                    dout_d  = word;
                    valid_d = 1'b1;
                end else begin
                    ovf_set = 1'b1;
                end
            end else if (valid_q && bus.ready) begin
                valid_d = 1'b0;
            end
        end
        // A drop in the same cycle as a clear keeps the overflow visible.
        ovf_d = ovf_set ? 1'b1 : (bus.clr_ovf ? 1'b0 : ovf_q);
    end

    always_ff @(posedge sclk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pd_q    <= 1'b0;
            busy_q  <= 1'b0;
            h0_q    <= '0;
            h1_q    <= '0;
            scnt_q  <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pd_q    <= pd_d;
            busy_q  <= busy_d;
            h0_q    <= h0_d;
            h1_q    <= h1_d;
            scnt_q  <= scnt_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.pd     = pd_q;
    assign bus.busy   = busy_q;
    assign bus.sample = tmr_sample;
    assign bus.dout   = dout_q;
    assign bus.valid  = valid_q;
    assign bus.ovf    = ovf_q;
    assign bus.state  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_ifs_bank_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_ifs_bank_ctrl : scoreboard bench for the input-register bank sequencer
// Rev 1.0
// ------------------------------------------------------------------
module tb_ifs_bank_ctrl;
    import ifs_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    ifs_bank_if #(.WIDTH(8), .DIV_W(8)) bus ();

    ifs_bank_ctrl #(
        .WIDTH     (8),
        .DIV_W     (8),
        .PD_CYCLES (2),
        .SETTLE    (4)
    ) dut (
        .sclk_i (clk),
        .rstn_i (rstn),
        .bus    (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    // reference model state
    logic [7:0] sb[$];
    logic [7:0] m_h0, m_h1;
    int         m_n, m_k, m_div;
    logic       m_run, m_ovf;

    // per-cycle observations and expectations filled by step()
    logic       obs_samp, obs_valid, obs_ovf;
    logic [7:0] obs_dout;
    logic       exp_samp, exp_valid, exp_ovf;
    logic       popped;
    logic [7:0] pop_word;

    function automatic logic [7:0] maj_ref(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = ((int'(a[i]) + int'(b[i]) + int'(c[i])) >= 2);
        end
        return r;
    endfunction

    task automatic m_reset();
        sb.delete();
        m_h0 = '0; m_h1 = '0; m_n = 0; m_k = 0; m_run = 1'b0; m_ovf = 1'b0;
    endtask

    // Observe current outputs, advance the model for this cycle, then clock once.
    task automatic step();
        logic [7:0] w;
        logic       drop;
        drop      = 1'b0;
        obs_samp  = bus.sample;
        obs_valid = bus.valid;
        obs_dout  = bus.dout;
        obs_ovf   = bus.ovf;
        exp_samp  = m_run && (m_k >= m_div) && (((m_k - m_div) % (m_div + 1)) == 0);
        exp_valid = (sb.size() != 0);
        exp_ovf   = m_ovf;
        popped    = 1'b0;
        if (!bus.en) begin
            sb.delete();
            m_h0 = '0; m_h1 = '0; m_n = 0; m_run = 1'b0; m_k = 0;
        end else begin
            if (exp_valid && bus.ready) begin
                pop_word = sb.pop_front();
                popped   = 1'b1;
            end
            if (exp_samp) begin
                if (m_n >= 2) begin
                    w = maj_ref(bus.q, m_h0, m_h1);
                    if (!exp_valid || bus.ready) sb.push_back(w);
                    else drop = 1'b1;
                end
                m_h1 = m_h0;
                m_h0 = bus.q;
                if (m_n < 3) m_n++;
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (bus.clr_ovf) m_ovf = 1'b0;
        if (m_run) m_k++;
        @(posedge clk);
        #1;
    endtask

    task automatic enable_to_run(input int div);
        bus.div = 8'(div);
        m_div   = div;
        bus.en  = 1'b1;
        repeat (7) step();
        m_run = 1'b1;
        m_k   = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({bus.pd, bus.sample, bus.valid, bus.ovf, bus.busy} !== 5'b0 || bus.dout !== 8'h00) begin
            $display("FAIL reset_outputs: pd=%b sample=%b valid=%b ovf=%b busy=%b dout=%h, required all 0",
                     bus.pd, bus.sample, bus.valid, bus.ovf, bus.busy, bus.dout);
        end else n_pass++;
        n_total++;
        if (bus.state !== ST_IDLE) $display("FAIL reset_state: got %0d required %0d", bus.state, ST_IDLE);
        else n_pass++;
        rstn = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            n_total++;
            if (bus.pd !== (i <= 2)) $display("FAIL reset_pd_c%0d: got %b required %b", i, bus.pd, (i <= 2));
            else n_pass++;
            n_total++;
            if (bus.busy !== (i <= 6)) $display("FAIL reset_busy_c%0d: got %b required %b", i, bus.busy, (i <= 6));
            else n_pass++;
            if (i == 7) begin
                n_total++;
                if (bus.state !== ST_RUN) $display("FAIL reset_run: got %0d required %0d", bus.state, ST_RUN);
                else n_pass++;
            end
        end
    endtask

    task automatic test_async_reset();
        #2 rstn = 1'b0;
        #1;
        n_total++;
        if (bus.state !== ST_IDLE || bus.busy !== 1'b0 || bus.sample !== 1'b0) begin
            $display("FAIL async_run: state=%0d busy=%b sample=%b required 0/0/0", bus.state, bus.busy, bus.sample);
        end else n_pass++;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        m_reset();
        step();
        n_total++;
        if (bus.pd !== 1'b1) $display("FAIL async_preset_pd: got %b required 1", bus.pd);
        else n_pass++;
        #2 rstn = 1'b0;
        #1;
        n_total++;
        if (bus.pd !== 1'b0 || bus.busy !== 1'b0 || bus.state !== ST_IDLE) begin
            $display("FAIL async_mid_preset: pd=%b busy=%b state=%0d required 0/0/0", bus.pd, bus.busy, bus.state);
        end else n_pass++;
        bus.en = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        m_reset();
    endtask

    task automatic test_div3();
        int pops;
        int first_v;
        pops = 0;
        first_v = -1;
        bus.en = 1'b0; bus.ready = 1'b1; bus.q = 8'hA5;
        step();
        enable_to_run(3);
        for (int k = 0; k < 20; k++) begin
            step();
            n_total++;
            if (obs_samp !== exp_samp) $display("FAIL div3_sample_k%0d: got %b required %b", k, obs_samp, exp_samp);
            else n_pass++;
            n_total++;
            if (obs_valid !== exp_valid) $display("FAIL div3_valid_k%0d: got %b required %b", k, obs_valid, exp_valid);
            else n_pass++;
            if (obs_valid === 1'b1 && first_v < 0) first_v = k;
            if (popped) begin
                pops++;
                n_total++;
                if (obs_dout !== pop_word) $display("FAIL div3_dout_k%0d: got %h required %h", k, obs_dout, pop_word);
                else n_pass++;
            end
        end
        n_total++;
        if (first_v !== 12) $display("FAIL div3_first_valid: got cycle %0d required 12", first_v);
        else n_pass++;
        n_total++;
        if (pops !== 2) $display("FAIL div3_word_count: got %0d required 2", pops);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int pops;
        pops = 0;
        bus.en = 1'b0; bus.ready = 1'b1; bus.q = 8'h00;
        step();
        enable_to_run(1);
        for (int k = 0; k < 20; k++) begin
            bus.q = (k == 7) ? 8'hFF : 8'h00;
            step();
            n_total++;
            if (obs_samp !== exp_samp) $display("FAIL glitch_sample_k%0d: got %b required %b", k, obs_samp, exp_samp);
            else n_pass++;
            if (popped) begin
                pops++;
                n_total++;
                if (obs_dout !== 8'h00) $display("FAIL glitch_dout_k%0d: got %h required 00", k, obs_dout);
                else n_pass++;
            end
        end
        n_total++;
        if (pops !== 7) $display("FAIL glitch_word_count: got %0d required 7", pops);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        bus.en = 1'b0; bus.ready = 1'b1; bus.q = 8'h3C; bus.clr_ovf = 1'b0;
        step();
        enable_to_run(1);
        for (int k = 0; k < 17; k++) begin
            bus.q       = (k >= 4) ? 8'hC3 : 8'h3C;
            bus.ready   = !(k >= 6 && k < 12);
            bus.clr_ovf = (k == 10 || k == 11);
            step();
            n_total++;
            if (obs_ovf !== exp_ovf) $display("FAIL bp_ovf_k%0d: got %b required %b", k, obs_ovf, exp_ovf);
            else n_pass++;
            n_total++;
            if (obs_valid !== exp_valid) $display("FAIL bp_valid_k%0d: got %b required %b", k, obs_valid, exp_valid);
            else n_pass++;
            if (popped) begin
                n_total++;
                if (obs_dout !== pop_word) $display("FAIL bp_dout_k%0d: got %h required %h", k, obs_dout, pop_word);
                else n_pass++;
            end
            if (k == 8) begin
                n_total++;
                if (obs_dout !== 8'h3C || obs_ovf !== 1'b1 || obs_valid !== 1'b1)
                    $display("FAIL bp_held: dout=%h ovf=%b valid=%b required 3c/1/1", obs_dout, obs_ovf, obs_valid);
                else n_pass++;
            end
            if (k == 11) begin
                n_total++;
                if (obs_ovf !== 1'b0) $display("FAIL bp_clr: got %b required 0", obs_ovf);
                else n_pass++;
            end
            if (k == 12) begin
                n_total++;
                if (obs_ovf !== 1'b1) $display("FAIL bp_clr_vs_set: got %b required 1", obs_ovf);
                else n_pass++;
            end
        end
        bus.clr_ovf = 1'b0;
    endtask

    task automatic test_en_drop();
        int pd_cnt;
        int pops;
        pd_cnt = 0;
        pops = 0;
        bus.en = 1'b0; bus.ready = 1'b0; bus.q = 8'h5A;
        step();
        enable_to_run(2);
        for (int k = 0; k < 10; k++) begin
            step();
            n_total++;
            if (obs_valid !== exp_valid) $display("FAIL endrop_valid_k%0d: got %b required %b", k, obs_valid, exp_valid);
            else n_pass++;
        end
        bus.en = 1'b0;
        step();
        n_total++;
        if (bus.valid !== 1'b0 || bus.state !== ST_IDLE)
            $display("FAIL endrop_idle: valid=%b state=%0d required 0/%0d", bus.valid, bus.state, ST_IDLE);
        else n_pass++;
        n_total++;
        if (bus.dout !== 8'h5A) $display("FAIL endrop_dout_hold: got %h required 5a", bus.dout);
        else n_pass++;
        n_total++;
        if (bus.ovf !== m_ovf) $display("FAIL endrop_ovf_hold: got %b required %b", bus.ovf, m_ovf);
        else n_pass++;
        bus.en = 1'b1; bus.q = 8'h96; bus.ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step();
            if (i == 0) begin
                n_total++;
                if (bus.pd !== 1'b1) $display("FAIL reen_pd_rise: got %b required 1", bus.pd);
                else n_pass++;
            end
            pd_cnt += int'(bus.pd);
        end
        n_total++;
        if (pd_cnt !== 2) $display("FAIL reen_pd_len: got %0d required 2", pd_cnt);
        else n_pass++;
        m_run = 1'b1;
        m_k   = 0;
        for (int k = 0; k < 12; k++) begin
            step();
            n_total++;
            if (obs_valid !== exp_valid) $display("FAIL reen_valid_k%0d: got %b required %b", k, obs_valid, exp_valid);
            else n_pass++;
            if (popped) begin
                pops++;
                n_total++;
                if (obs_dout !== 8'h96) $display("FAIL reen_dout_k%0d: got %h required 96", k, obs_dout);
                else n_pass++;
            end
        end
        n_total++;
        if (pops !== 1) $display("FAIL reen_word_count: got %0d required 1", pops);
        else n_pass++;
    endtask

    task automatic test_div0();
        bus.en = 1'b0; bus.ready = 1'b1;
        step();
        enable_to_run(0);
        for (int k = 0; k < 15; k++) begin
            bus.q = 8'($urandom);
            step();
            n_total++;
            if (obs_samp !== 1'b1) $display("FAIL div0_sample_k%0d: got %b required 1", k, obs_samp);
            else n_pass++;
            n_total++;
            if (obs_valid !== (k >= 3)) $display("FAIL div0_valid_k%0d: got %b required %b", k, obs_valid, (k >= 3));
            else n_pass++;
            if (popped) begin
                n_total++;
                if (obs_dout !== pop_word) $display("FAIL div0_dout_k%0d: got %h required %h", k, obs_dout, pop_word);
                else n_pass++;
            end
        end
    endtask

    initial begin
        bus.en      = 1'b1;
        bus.div     = 8'd3;
        bus.q       = 8'h00;
        bus.ready   = 1'b0;
        bus.clr_ovf = 1'b0;
        m_div       = 3;
        m_reset();
        test_reset();
        test_async_reset();
        test_div3();
        test_glitch();
        test_backpressure();
        test_en_drop();
        test_div0();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
